calc_key_sequencer: RTL and testbench

//  Upstream input stage for the four-function calculator.
//  - Synchronises and debounces raw board KEYs.
//  - Runs an operand-entry FSM: SW value -> operand A, SW value -> operand B, SW[9:8] -> opcode.
//  - Issues one operation request per EXECUTE press over a valid/ready handshake, which the calculator core consumes.

---
 rtl/calc_key_sequencer_pkg.sv | 25 ++
 rtl/calc_key_sequencer_if.sv | 33 +++
 rtl/calc_key_sequencer_key_debounce.sv | 64 ++++++
 rtl/calc_key_sequencer.sv | 110 +++++++++++
 tb/tb_calc_key_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/calc_key_sequencer_pkg.sv
// Shared definitions for the calculator key sequencer.
// Contents:
//   - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV (values driven on op_code)
//   - FSM state encoding (also shown on LEDR, so the codes are fixed)
//   - key index constants K_ENTER/K_EXEC/K_CLEAR into key_n
package calc_key_sequencer_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        S_ENTER_A = 2'd0,
        S_ENTER_B = 2'd1,
        S_READY   = 2'd2,
        S_ISSUE   = 2'd3
    } state_e;

    localparam int K_ENTER  = 0;
    localparam int K_EXEC   = 1;
    localparam int K_CLEAR  = 2;
    localparam int NUM_KEYS = 3;

endpackage

// File: rtl/calc_key_sequencer_if.sv
// Operation request channel from the key sequencer to the calculator core.
// Signals:
//   op_valid  request present (held until accepted)
//   op_ready  core can accept a request
//   op_a      operand A, DATA_W bits
//   op_b      operand B, DATA_W bits
//   op_code   0=ADD 1=SUB 2=MUL 3=DIV
// Modports: master = sequencer side, slave = calculator core side.
interface calc_key_sequencer_if #(
    parameter int DATA_W = 8
) ();
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [1:0]        op_code;

    modport master (
        output op_valid,
        output op_a,
        output op_b,
        output op_code,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_a,
        input  op_b,
        input  op_code,
        output op_ready
    );
endinterface

// File: rtl/calc_key_sequencer_key_debounce.sv
// Key conditioning for one active-low board key: 2-FF synchroniser,
// debouncer and single-cycle press pulse.
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   key_n_i  raw active-low key, asynchronous to clk
//   press_o  one-cycle pulse, the cycle after the debounced level falls
module calc_key_sequencer_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic press_o
);
    // Counter only ever holds 0..DEBOUNCE_CYCLES-1; the flip happens on the
    // edge where it would have reached DEBOUNCE_CYCLES.
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_dly_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= key_n_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            // Falling edge of the debounced level, seen one cycle late.
            press_q     <= level_dly_q & ~level_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/calc_key_sequencer.sv
// Upstream input stage of the four-function calculator: debounces the
// ENTER/EXECUTE/CLEAR keys, runs the operand-entry FSM and issues one
// operation request per EXECUTE press over a valid/ready channel.
// Ports:
//   clk     system clock
//   reset   synchronous active-high reset
//   key_n   raw active-low keys: [0]=ENTER [1]=EXECUTE [2]=CLEAR [3]=unused
//   sw      switches: [DATA_W-1:0]=operand value, [9:8]=opcode
//   op      request channel (master side): op_valid/op_a/op_b/op_code out, op_ready in
//   state   FSM state code for LEDR
module calc_key_sequencer
    import calc_key_sequencer_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              key_n,
    input  logic [9:0]              sw,
    calc_key_sequencer_if.master    op,
    output logic [1:0]              state
);
    logic [NUM_KEYS-1:0] press_w;

    // KEY[3] has no function on this board.
    logic unused_key3;
    assign unused_key3 = key_n[3];

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            calc_key_sequencer_key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_key (
                .clk     (clk),
                .reset   (reset),
                .key_n_i (key_n[gi]),
                .press_o (press_w[gi])
            );
        end
    endgenerate

    state_e            state_q,    state_d;
    logic [DATA_W-1:0] op_a_q,     op_a_d;
    logic [DATA_W-1:0] op_b_q,     op_b_d;
    logic [1:0]        op_code_q,  op_code_d;
    logic              op_valid_q, op_valid_d;

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_code_d  = op_code_q;
        op_valid_d = op_valid_q;

        if (state_q == S_ISSUE) begin
            // Keys are dropped here; the request is only retired by the handshake.
            if (op_valid_q && op.op_ready) begin
                op_valid_d = 1'b0;
                state_d    = S_ENTER_A;
            end
        end else if (press_w[K_CLEAR]) begin
            state_d = S_ENTER_A;
            op_a_d  = '0;
            op_b_d  = '0;
        end else if (press_w[K_EXEC] && (state_q == S_READY)) begin
            op_code_d  = sw[9:8];
            op_valid_d = 1'b1;
            state_d    = S_ISSUE;
        end else if (press_w[K_ENTER]) begin
            // EXECUTE outside READY has no effect, so ENTER is free to act.
            case (state_q)
                S_ENTER_A: begin
                    op_a_d  = sw[DATA_W-1:0];
                    state_d = S_ENTER_B;
                end
                S_ENTER_B: begin
                    op_b_d  = sw[DATA_W-1:0];
                    state_d = S_READY;
                end
                default: begin
                    op_b_d = sw[DATA_W-1:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_ENTER_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_code_q  <= OP_ADD;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_code_q  <= op_code_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign op.op_valid = op_valid_q;
    assign op.op_a     = op_a_q;
    assign op.op_b     = op_b_q;
    assign op.op_code  = op_code_q;
    assign state       = state_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer with DEBOUNCE_CYCLES=4.
module tb_calc_key_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic [9:0] sw;
    logic [1:0] state;

    calc_key_sequencer_if #(.DATA_W(8)) bus ();

    calc_key_sequencer #(
        .DATA_W          (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n),
        .sw    (sw),
        .op    (bus),
        .state (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor: counts valid cycles and transfers, records the transferred
    // fields and flags any change of the request while it is stalled.
    int         valid_total = 0;
    int         xfer_total  = 0;
    int         stall_bad   = 0;
    logic [7:0] xfer_a, xfer_b;
    logic [1:0] xfer_code;
    logic       mon_en = 1'b0;
    logic [7:0] snap_a, snap_b;
    logic [1:0] snap_code;

    always @(negedge clk) begin
        if (bus.op_valid === 1'b1) valid_total = valid_total + 1;
        if (bus.op_valid === 1'b1 && bus.op_ready === 1'b1) begin
            xfer_total = xfer_total + 1;
            xfer_a     = bus.op_a;
            xfer_b     = bus.op_b;
            xfer_code  = bus.op_code;
        end
        if (mon_en) begin
            if (bus.op_valid !== 1'b1 || bus.op_a !== snap_a || bus.op_b !== snap_b ||
                bus.op_code !== snap_code || state !== 2'd3)
                stall_bad = stall_bad + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold the keys in mask low long enough to debounce, then release
    // long enough for the release to debounce too.
    task automatic press(input logic [3:0] mask, input logic [9:0] sw_val);
        sw    = sw_val;
        key_n = ~mask;
        repeat (10) @(negedge clk);
        key_n = 4'b1111;
        repeat (10) @(negedge clk);
        $display("press keys=%b sw=%0d -> state=%0d a=%0d b=%0d valid=%0d",
                 mask, sw_val, state, bus.op_a, bus.op_b, bus.op_valid);
    endtask

    int v0, x0;

    initial begin
        reset        = 1'b1;
        key_n        = 4'b1111;
        sw           = '0;
        bus.op_ready = 1'b1;

        // 1. Reset
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_valid", bus.op_valid, 0);
        check("rst_a", bus.op_a, 0);
        check("rst_b", bus.op_b, 0);
        check("rst_code", bus.op_code, 0);
        check("rst_state", state, 0);
        repeat (50) @(negedge clk);
        check("idle_state", state, 0);
        check("idle_valid", valid_total, 0);

        // 2. Full entry with op_ready high
        press(4'b0001, 10'd12);
        check("s2_stateB", state, 1);
        check("s2_a", bus.op_a, 12);
        press(4'b0001, 10'd5);
        check("s2_stateR", state, 2);
        check("s2_b", bus.op_b, 5);
        v0 = valid_total; x0 = xfer_total;
        press(4'b0010, {2'b01, 8'd0});
        check("s2_xfers", xfer_total - x0, 1);
        check("s2_valid_cycles", valid_total - v0, 1);
        check("s2_xa", xfer_a, 12);
        check("s2_xb", xfer_b, 5);
        check("s2_xcode", xfer_code, 1);
        check("s2_state", state, 0);
        check("s2_code_kept", bus.op_code, 1);

        // 3. Back-pressure, keys dropped during ISSUE
        press(4'b0001, 10'd200);
        press(4'b0001, 10'd7);
        bus.op_ready = 1'b0;
        x0 = xfer_total;
        press(4'b0010, {2'b11, 8'd99});
        check("s3_valid", bus.op_valid, 1);
        check("s3_state", state, 3);
        snap_a = 8'd200; snap_b = 8'd7; snap_code = 2'd3;
        mon_en = 1'b1;
        press(4'b0100, 10'd0);
        press(4'b0001, 10'd55);
        mon_en = 1'b0;
        check("s3_stable", stall_bad, 0);
        check("s3_no_xfer", xfer_total - x0, 0);
        bus.op_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("s3_xfers", xfer_total - x0, 1);
        check("s3_xa", xfer_a, 200);
        check("s3_xb", xfer_b, 7);
        check("s3_xcode", xfer_code, 3);
        check("s3_state", state, 0);
        check("s3_valid_low", bus.op_valid, 0);

        // 4. Bounce on ENTER: low glitches of 1..3 cycles
        sw = 10'd33;
        for (int i = 0; i < 8; i++) begin
            key_n[0] = 1'b0;
            repeat ((i % 3) + 1) @(negedge clk);
            key_n[0] = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("s4_bounce_state", state, 0);
        check("s4_bounce_a", bus.op_a, 200);
        press(4'b0001, 10'd33);
        check("s4_one_capture", state, 1);
        check("s4_a", bus.op_a, 33);

        // 5. CLEAR and EXECUTE together in READY
        press(4'b0001, 10'd44);
        check("s5_ready", state, 2);
        check("s5_b", bus.op_b, 44);
        v0 = valid_total;
        press(4'b0110, {2'b10, 8'd1});
        check("s5_state", state, 0);
        check("s5_a", bus.op_a, 0);
        check("s5_b0", bus.op_b, 0);
        check("s5_no_valid", valid_total - v0, 0);

        // 6. Reset mid-ISSUE, then a fresh sequence
        press(4'b0001, 10'd9);
        press(4'b0001, 10'd3);
        bus.op_ready = 1'b0;
        press(4'b0010, {2'b10, 8'd0});
        check("s6_issue", state, 3);
        reset = 1'b1;
        @(negedge clk);
        check("s6_rst_valid", bus.op_valid, 0);
        check("s6_rst_state", state, 0);
        reset = 1'b0;
        bus.op_ready = 1'b1;
        x0 = xfer_total;
        press(4'b0001, 10'd100);
        press(4'b0001, 10'd25);
        press(4'b0010, {2'b00, 8'd0});
        check("s6_xfers", xfer_total - x0, 1);
        check("s6_xa", xfer_a, 100);
        check("s6_xb", xfer_b, 25);
        check("s6_xcode", xfer_code, 0);
        check("s6_state", state, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
